// File: rtl/riscv_dmem_resp_if.sv
// LSU data-memory request/response channel: valid/ready request in, valid/ready response out.
interface riscv_dmem_resp_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_wen, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: one access at a time, fixed latency, byte/half/word stores into a word array.
// Define RISCV_DMEM_MISALIGN_CHK_EN to fault misaligned half/word accesses instead of force-aligning them.
module riscv_dmem_resp #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input logic               clk,
  input logic               rst,
  riscv_dmem_resp_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wen_q, wen_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  range_fault, size_fault, align_fault, fault;
  logic [DATA_WIDTH-1:0] rd_shifted, load_data, wdata_sh;
  logic [3:0]            be;
  logic                  commit, mem_we;

  assign bus.req_ready = (state_q == S_IDLE) & ~rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Address decode off the latched request; addresses below the base wrap to a huge offset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    off         = addr_q - BASE_ADDR;
    idx         = off[DEPTH_LOG2+1:2];
    range_fault = |off[ADDR_WIDTH-1:DEPTH_LOG2+2];
    size_fault  = (size_q == 2'd3);
    lane        = off[1:0];
    align_fault = 1'b0;
`ifdef RISCV_DMEM_MISALIGN_CHK_EN
    align_fault = ((size_q == 2'd1) && off[0]) || ((size_q == 2'd2) && (off[1:0] != 2'd0));
`else
    case (size_q)
      2'd1:    lane = {off[1], 1'b0};
      2'd2:    lane = 2'd0;
      default: lane = off[1:0];
    endcase
`endif
    fault = range_fault | size_fault | align_fault;

    rd_shifted = mem[idx] >> {lane, 3'b000};
    case (size_q)
      2'd0:    load_data = {24'd0, rd_shifted[7:0]};
      2'd1:    load_data = {16'd0, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase

    wdata_sh = wdata_q << {lane, 3'b000};
    case (size_q)
      2'd0:    be = 4'b0001 << lane;
      2'd1:    be = 4'b0011 << lane;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase

    commit = (state_q == S_WAIT) && (cnt_q == '0);
    mem_we = commit & wen_q & ~fault;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          wen_d   = bus.req_wen;
          size_d  = bus.req_size;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = fault;
          rsp_rdata_d = (fault || wen_q) ? '0 : load_data;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wen_q       <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: the array has no reset so it can map onto RAM; a reset mid-WAIT clears state_q and blocks the write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Self-checking bench for riscv_dmem_resp: scoreboard of expected responses, latency, backpressure, faults, reset.
module tb_riscv_dmem_resp;

  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  riscv_dmem_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  riscv_dmem_resp #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH_LOG2(12),
    .BASE_ADDR (32'h8000_0000),
    .LATENCY   (LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) check("req_ready_timeout", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic collect(input bit chk_lat);
    int   k = 0;
    exp_t e;
    while (bus.rsp_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (bus.rsp_valid !== 1'b1) begin
      check("rsp_timeout", bus.rsp_valid, 1);
    end else begin
      if (chk_lat) check("latency", k, LATENCY);
      if (sb.size() == 0) begin
        check("unexpected_rsp", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        check({e.tag, "_err"}, bus.rsp_err, e.err);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("rsp_valid_cleared", bus.rsp_valid, 0);
    end
  endtask

  task automatic access(input string tag, input logic wen, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    expect_rsp(tag, exp_rdata, exp_err);
    send(wen, size, addr, wdata);
    collect(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_rsp_rdata", bus.rsp_rdata, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", bus.req_ready, 1);

    // Latency and basic word store/load.
    access("st_word",   1'b1, 2'd2, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access("ld_word",   1'b0, 2'd2, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Sub-word ops.
    access("st_byte3",  1'b1, 2'd0, 32'h8000_0003, 32'h0000_005A, 32'h0, 1'b0);
    access("ld_word_b", 1'b0, 2'd2, 32'h8000_0000, 32'h0, 32'h5AAD_BEEF, 1'b0);
    access("ld_half2",  1'b0, 2'd1, 32'h8000_0002, 32'h0, 32'h0000_5AAD, 1'b0);
    access("ld_byte1",  1'b0, 2'd0, 32'h8000_0001, 32'h0, 32'h0000_00BE, 1'b0);
    access("st_word4",  1'b1, 2'd2, 32'h8000_0004, 32'h0000_0000, 32'h0, 1'b0);
    access("st_half6",  1'b1, 2'd1, 32'h8000_0006, 32'h1234_BEEF, 32'h0, 1'b0);
    access("st_byte4",  1'b1, 2'd0, 32'h8000_0004, 32'hFFFF_FF77, 32'h0, 1'b0);
    access("ld_word4",  1'b0, 2'd2, 32'h8000_0004, 32'h0, 32'hBEEF_0077, 1'b0);

    // Backpressure: response held for 5 cycles while a new request waits.
    expect_rsp("bp_first", 32'h5AAD_BEEF, 1'b0);
    send(1'b0, 2'd2, 32'h8000_0000, 32'h0);
    for (int i = 0; i < 10 && bus.rsp_valid !== 1'b1; i++) @(negedge clk);
    expect_rsp("bp_second", 32'h0000_00AD, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = 32'h8000_0002;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_rdata", bus.rsp_rdata, 32'h5AAD_BEEF);
      check("bp_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    collect(1'b0);
    check("bp_ready_after_retire", bus.req_ready, 1);
    @(negedge clk);
    check("bp_accepted_once", bus.req_ready, 0);
    bus.req_valid = 1'b0;
    collect(1'b1);

    // Faults.
    access("ld_below_base", 1'b0, 2'd2, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1);
    access("st_above_top",  1'b1, 2'd2, 32'h8000_4000, 32'h0BAD_F00D, 32'h0, 1'b1);
    access("ld_after_oob",  1'b0, 2'd2, 32'h8000_0000, 32'h0, 32'h5AAD_BEEF, 1'b0);
    access("ld_size3",      1'b0, 2'd3, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
    access("st_size3",      1'b1, 2'd3, 32'h8000_0000, 32'h1111_1111, 32'h0, 1'b1);
    access("ld_after_sz3",  1'b0, 2'd2, 32'h8000_0000, 32'h0, 32'h5AAD_BEEF, 1'b0);
    access("st_last_word",  1'b1, 2'd2, 32'h8000_3FFC, 32'hA5A5_0F0F, 32'h0, 1'b0);
    access("ld_last_word",  1'b0, 2'd2, 32'h8000_3FFC, 32'h0, 32'hA5A5_0F0F, 1'b0);

    // Misaligned accesses.
`ifdef RISCV_DMEM_MISALIGN_CHK_EN
    access("ld_word_mis", 1'b0, 2'd2, 32'h8000_0002, 32'h0, 32'h0, 1'b1);
    access("ld_half_mis", 1'b0, 2'd1, 32'h8000_0003, 32'h0, 32'h0, 1'b1);
`else
    access("ld_word_mis", 1'b0, 2'd2, 32'h8000_0002, 32'h0, 32'h5AAD_BEEF, 1'b0);
    access("ld_half_mis", 1'b0, 2'd1, 32'h8000_0003, 32'h0, 32'h0000_5AAD, 1'b0);
`endif

    // Reset in the middle of a pending store drops it.
    access("st_pre_rst", 1'b1, 2'd2, 32'h8000_0010, 32'h1122_3344, 32'h0, 1'b0);
    send(1'b1, 2'd2, 32'h8000_0010, 32'hCAFE_F00D);
    rst = 1'b1;
    #1;
    check("rst_mid_rsp_valid", bus.rsp_valid, 0);
    check("rst_mid_req_ready", bus.req_ready, 0);
    repeat (3) @(negedge clk);
    check("rst_hold_rsp_valid", bus.rsp_valid, 0);
    check("rst_hold_req_ready", bus.req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rsp_valid", bus.rsp_valid, 0);
    access("ld_post_rst", 1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'h1122_3344, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
